// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the instruction/data memory port arbiter:
// state encodings, the starvation limit default and the grant-priority rule.
package mem_port_arbiter_pkg;

    localparam int STARVE_LIMIT_DEFAULT = 4;
    localparam int STREAK_W             = 3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DATA = 2'd1,
        INST = 2'd2
    } arb_state_e;

    // Data wins unless a fetch is waiting and data has already had its full streak.
    function automatic logic data_wins(input logic dm_req,
                                       input logic if_req,
                                       input logic at_limit);
        return dm_req & (~if_req | ~at_limit);
    endfunction

endpackage

// File: rtl/arb_streak_counter.sv
// Saturating count of consecutive data grants made while a fetch was waiting.
module arb_streak_counter
    import mem_port_arbiter_pkg::*;
#(
    parameter int LIMIT = STARVE_LIMIT_DEFAULT
) (
    input  logic clock,
    input  logic reset_n,
    input  logic inc_i,
    input  logic clr_i,
    output logic streak_at_limit
);

    localparam logic [STREAK_W-1:0] LIMIT_W = STREAK_W'(LIMIT);

    logic [STREAK_W-1:0] streak_q;
    logic [STREAK_W-1:0] streak_d;
    logic                at_limit_s;

    assign at_limit_s = (streak_q >= LIMIT_W);

    // Clear has priority over increment; increment stops at the limit.
    always_comb begin
        streak_d = streak_q;
        if (clr_i) begin
            streak_d = {STREAK_W{1'b0}};
        end else if (inc_i && !at_limit_s) begin
            streak_d = streak_q + {{(STREAK_W-1){1'b0}}, 1'b1};
        end else begin
            streak_d = streak_q;
        end
    end

    // Streak register.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            streak_q <= {STREAK_W{1'b0}};
        end else begin
            streak_q <= streak_d;
        end
    end

    assign streak_at_limit = at_limit_s;

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates a fetch port and a data port onto one single-port memory,
// with a bounded data streak so fetches cannot starve.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int STARVE_LIMIT = STARVE_LIMIT_DEFAULT
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        w_if_req,
    input  logic [31:0] w_if_addr_32,
    input  logic        w_if_flush,
    output logic [31:0] w_if_rdata_32,
    output logic        w_if_valid,
    input  logic        w_dm_req,
    input  logic        w_dm_write,
    input  logic [31:0] w_dm_addr_32,
    input  logic [31:0] w_dm_wdata_32,
    output logic [31:0] w_dm_rdata_32,
    output logic        w_dm_valid,
    output logic        w_mem_req,
    output logic        w_mem_write,
    output logic [31:0] w_mem_addr_32,
    output logic [31:0] w_mem_wdata_32,
    input  logic [31:0] w_mem_rdata_32,
    input  logic        w_mem_ready,
    output logic        w_stall_fetch,
    output logic        w_stall_mem
);

    arb_state_e  state_q,    state_d;
    logic [31:0] addr_q,     addr_d;
    logic [31:0] wdata_q,    wdata_d;
    logic        write_q,    write_d;
    logic        mem_req_q,  mem_req_d;
    logic [31:0] if_rdata_q, if_rdata_d;
    logic [31:0] dm_rdata_q, dm_rdata_d;
    logic        if_valid_q, if_valid_d;
    logic        dm_valid_q, dm_valid_d;
    logic        flushed_q,  flushed_d;

    logic grant_data_s;
    logic grant_inst_s;
    logic streak_inc_s;
    logic streak_clr_s;
    logic streak_at_limit_s;

    arb_streak_counter #(
        .LIMIT (STARVE_LIMIT)
    ) u_streak (
        .clock           (clock),
        .reset_n         (reset_n),
        .inc_i           (streak_inc_s),
        .clr_i           (streak_clr_s),
        .streak_at_limit (streak_at_limit_s)
    );

    assign streak_inc_s = grant_data_s & w_if_req;
    assign streak_clr_s = grant_inst_s | (grant_data_s & ~w_if_req);

    // Arbitration, access tracking and completion capture.
    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        write_d      = write_q;
        mem_req_d    = mem_req_q;
        if_rdata_d   = if_rdata_q;
        dm_rdata_d   = dm_rdata_q;
        if_valid_d   = 1'b0;
        dm_valid_d   = 1'b0;
        flushed_d    = flushed_q;
        grant_data_s = 1'b0;
        grant_inst_s = 1'b0;

        case (state_q)
            IDLE: begin
                if (data_wins(w_dm_req, w_if_req, streak_at_limit_s)) begin
                    grant_data_s = 1'b1;
                    state_d      = DATA;
                    addr_d       = w_dm_addr_32;
                    wdata_d      = w_dm_wdata_32;
                    write_d      = w_dm_write;
                    mem_req_d    = 1'b1;
                end else if (w_if_req) begin
                    grant_inst_s = 1'b1;
                    state_d      = INST;
                    addr_d       = w_if_addr_32;
                    wdata_d      = 32'h0000_0000;
                    write_d      = 1'b0;
                    mem_req_d    = 1'b1;
                    flushed_d    = w_if_flush;
                end else begin
                    state_d      = IDLE;
                end
            end
            DATA: begin
                if (w_mem_ready) begin
                    state_d    = IDLE;
                    mem_req_d  = 1'b0;
                    write_d    = 1'b0;
                    dm_valid_d = 1'b1;
                    if (!write_q) begin
                        dm_rdata_d = w_mem_rdata_32;
                    end else begin
                        dm_rdata_d = dm_rdata_q;
                    end
                end else begin
                    state_d = DATA;
                end
            end
            INST: begin
                // A flushed fetch still finishes at the memory but is never delivered.
                if (w_mem_ready) begin
                    state_d   = IDLE;
                    mem_req_d = 1'b0;
                    flushed_d = 1'b0;
                    if (flushed_q || w_if_flush) begin
                        if_valid_d = 1'b0;
                    end else begin
                        if_valid_d = 1'b1;
                        if_rdata_d = w_mem_rdata_32;
                    end
                end else begin
                    state_d   = INST;
                    flushed_d = flushed_q | w_if_flush;
                end
            end
            default: begin
                state_d   = IDLE;
                mem_req_d = 1'b0;
                write_d   = 1'b0;
                flushed_d = 1'b0;
            end
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            addr_q     <= 32'h0000_0000;
            wdata_q    <= 32'h0000_0000;
            write_q    <= 1'b0;
            mem_req_q  <= 1'b0;
            if_rdata_q <= 32'h0000_0000;
            dm_rdata_q <= 32'h0000_0000;
            if_valid_q <= 1'b0;
            dm_valid_q <= 1'b0;
            flushed_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            write_q    <= write_d;
            mem_req_q  <= mem_req_d;
            if_rdata_q <= if_rdata_d;
            dm_rdata_q <= dm_rdata_d;
            if_valid_q <= if_valid_d;
            dm_valid_q <= dm_valid_d;
            flushed_q  <= flushed_d;
        end
    end

    assign w_mem_req      = mem_req_q;
    assign w_mem_write    = write_q;
    assign w_mem_addr_32  = addr_q;
    assign w_mem_wdata_32 = wdata_q;
    assign w_if_rdata_32  = if_rdata_q;
    assign w_if_valid     = if_valid_q;
    assign w_dm_rdata_32  = dm_rdata_q;
    assign w_dm_valid     = dm_valid_q;
    assign w_stall_fetch  = w_if_req & ~if_valid_q;
    assign w_stall_mem    = w_dm_req & ~dm_valid_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: a table of single transactions plus
// hand-written sequences for starvation, flush, idle-ready and mid-access reset.
module tb_mem_port_arbiter;

    logic        clock;
    logic        reset_n;
    logic        w_if_req;
    logic [31:0] w_if_addr_32;
    logic        w_if_flush;
    logic [31:0] w_if_rdata_32;
    logic        w_if_valid;
    logic        w_dm_req;
    logic        w_dm_write;
    logic [31:0] w_dm_addr_32;
    logic [31:0] w_dm_wdata_32;
    logic [31:0] w_dm_rdata_32;
    logic        w_dm_valid;
    logic        w_mem_req;
    logic        w_mem_write;
    logic [31:0] w_mem_addr_32;
    logic [31:0] w_mem_wdata_32;
    logic [31:0] w_mem_rdata_32;
    logic        w_mem_ready;
    logic        w_stall_fetch;
    logic        w_stall_mem;

    mem_port_arbiter #(.STARVE_LIMIT(4)) dut (
        .clock          (clock),
        .reset_n        (reset_n),
        .w_if_req       (w_if_req),
        .w_if_addr_32   (w_if_addr_32),
        .w_if_flush     (w_if_flush),
        .w_if_rdata_32  (w_if_rdata_32),
        .w_if_valid     (w_if_valid),
        .w_dm_req       (w_dm_req),
        .w_dm_write     (w_dm_write),
        .w_dm_addr_32   (w_dm_addr_32),
        .w_dm_wdata_32  (w_dm_wdata_32),
        .w_dm_rdata_32  (w_dm_rdata_32),
        .w_dm_valid     (w_dm_valid),
        .w_mem_req      (w_mem_req),
        .w_mem_write    (w_mem_write),
        .w_mem_addr_32  (w_mem_addr_32),
        .w_mem_wdata_32 (w_mem_wdata_32),
        .w_mem_rdata_32 (w_mem_rdata_32),
        .w_mem_ready    (w_mem_ready),
        .w_stall_fetch  (w_stall_fetch),
        .w_stall_mem    (w_stall_mem)
    );

    typedef struct {
        logic        is_data;
        logic        write;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] mrdata;
        int          delay;
        logic [31:0] exp_rdata;
    } vec_t;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] exp_if   = 32'h0;
    logic [31:0] exp_dm   = 32'h0;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // One complete transaction; entered and left just after a rising edge with the FSM idle.
    task automatic run_txn(input vec_t v, input string nm);
        if (v.is_data) begin
            w_dm_req      = 1'b1;
            w_dm_write    = v.write;
            w_dm_addr_32  = v.addr;
            w_dm_wdata_32 = v.wdata;
        end else begin
            w_if_req      = 1'b1;
            w_if_addr_32  = v.addr;
        end
        w_mem_ready = 1'b0;
        @(negedge clock);
        chk({nm, "_grant_cycle_mem_req"}, 32'(w_mem_req), 32'h0);
        @(posedge clock); #1;
        for (int k = 0; k <= v.delay; k++) begin
            w_mem_ready    = (k == v.delay);
            w_mem_rdata_32 = (k == v.delay) ? v.mrdata : 32'h0BAD_0BAD;
            @(negedge clock);
            chk({nm, "_mem_req"},   32'(w_mem_req),   32'h1);
            chk({nm, "_mem_write"}, 32'(w_mem_write), 32'(v.write));
            chk({nm, "_mem_addr"},  w_mem_addr_32,    v.addr);
            if (v.write) chk({nm, "_mem_wdata"}, w_mem_wdata_32, v.wdata);
            chk({nm, "_early_valid"}, 32'(w_if_valid | w_dm_valid), 32'h0);
            chk({nm, "_stall"}, 32'(v.is_data ? w_stall_mem : w_stall_fetch), 32'h1);
            @(posedge clock); #1;
        end
        w_mem_ready = 1'b0;
        if (v.is_data) begin
            chk({nm, "_dm_valid"},   32'(w_dm_valid),  32'h1);
            chk({nm, "_if_valid"},   32'(w_if_valid),  32'h0);
            chk({nm, "_stall_mem"},  32'(w_stall_mem), 32'h0);
            chk({nm, "_dm_rdata"},   w_dm_rdata_32,    v.exp_rdata);
            chk({nm, "_if_rdata"},   w_if_rdata_32,    exp_if);
            exp_dm = v.exp_rdata;
        end else begin
            chk({nm, "_if_valid"},    32'(w_if_valid),    32'h1);
            chk({nm, "_dm_valid"},    32'(w_dm_valid),    32'h0);
            chk({nm, "_stall_fetch"}, 32'(w_stall_fetch), 32'h0);
            chk({nm, "_if_rdata"},    w_if_rdata_32,      v.exp_rdata);
            chk({nm, "_dm_rdata"},    w_dm_rdata_32,      exp_dm);
            exp_if = v.exp_rdata;
        end
        chk({nm, "_done_mem_req"}, 32'(w_mem_req), 32'h0);
        w_dm_req = 1'b0;
        w_if_req = 1'b0;
        @(posedge clock); #1;
        chk({nm, "_pulse_end"}, 32'(w_if_valid | w_dm_valid), 32'h0);
    endtask

    initial begin
        vec_t        vecs [6];
        vec_t        tail;
        logic [9:0]  gseq_exp;
        int          g;
        logic        seen;

        vecs[0] = '{1'b0, 1'b0, 32'h0000_0040, 32'h0,         32'hDEAD_BEEF, 0, 32'hDEAD_BEEF};
        vecs[1] = '{1'b1, 1'b0, 32'h0000_0200, 32'h0,         32'hCAFE_F00D, 1, 32'hCAFE_F00D};
        vecs[2] = '{1'b1, 1'b1, 32'h0000_0100, 32'h1234_5678, 32'hBAD0_BAD0, 3, 32'hCAFE_F00D};
        vecs[3] = '{1'b0, 1'b0, 32'h0000_0044, 32'h0,         32'h0000_0013, 2, 32'h0000_0013};
        vecs[4] = '{1'b1, 1'b0, 32'hFFFF_FFFC, 32'h0,         32'hFFFF_FFFF, 0, 32'hFFFF_FFFF};
        vecs[5] = '{1'b1, 1'b1, 32'h0000_0000, 32'h0000_0000, 32'h5A5A_5A5A, 0, 32'hFFFF_FFFF};

        reset_n        = 1'b0;
        w_if_req       = 1'b0;
        w_if_addr_32   = 32'h0;
        w_if_flush     = 1'b0;
        w_dm_req       = 1'b0;
        w_dm_write     = 1'b0;
        w_dm_addr_32   = 32'h0;
        w_dm_wdata_32  = 32'h0;
        w_mem_rdata_32 = 32'h0;
        w_mem_ready    = 1'b0;
        #2;
        chk("rst_mem_req",   32'(w_mem_req),   32'h0);
        chk("rst_mem_write", 32'(w_mem_write), 32'h0);
        chk("rst_mem_addr",  w_mem_addr_32,    32'h0);
        chk("rst_mem_wdata", w_mem_wdata_32,   32'h0);
        chk("rst_valids",    32'(w_if_valid | w_dm_valid), 32'h0);
        chk("rst_if_rdata",  w_if_rdata_32,    32'h0);
        chk("rst_dm_rdata",  w_dm_rdata_32,    32'h0);
        chk("rst_stalls",    32'(w_stall_fetch | w_stall_mem), 32'h0);
        @(posedge clock); #1;
        reset_n = 1'b1;
        @(posedge clock); #1;

        for (int i = 0; i < 6; i++) begin
            run_txn(vecs[i], $sformatf("vec%0d", i));
        end

        // Ready while idle must not produce any completion.
        w_mem_ready    = 1'b1;
        w_mem_rdata_32 = 32'h1357_9BDF;
        for (int c = 0; c < 3; c++) begin
            @(negedge clock);
            chk("idle_ready_mem_req", 32'(w_mem_req), 32'h0);
            chk("idle_ready_valid",   32'(w_if_valid | w_dm_valid), 32'h0);
        end
        @(posedge clock); #1;
        w_mem_ready = 1'b0;
        chk("idle_ready_if_rdata", w_if_rdata_32, exp_if);
        chk("idle_ready_dm_rdata", w_dm_rdata_32, exp_dm);

        // Both requesters held high: D,D,D,D,I repeating (bit set = fetch grant).
        gseq_exp       = 10'b1000010000;
        g              = 0;
        w_mem_ready    = 1'b1;
        w_mem_rdata_32 = 32'h5555_AAAA;
        w_if_addr_32   = 32'h0000_0080;
        w_dm_addr_32   = 32'h0000_0300;
        w_dm_write     = 1'b0;
        w_if_req       = 1'b1;
        w_dm_req       = 1'b1;
        for (int c = 0; c < 40 && g < 10; c++) begin
            @(negedge clock);
            if (w_mem_req) begin
                chk($sformatf("starve_grant%0d_is_fetch", g),
                    32'(w_mem_addr_32 == 32'h0000_0080), 32'(gseq_exp[g]));
                g++;
            end
            chk("starve_valid_excl", 32'(w_if_valid & w_dm_valid), 32'h0);
            chk("starve_stall_fetch", 32'(w_stall_fetch), w_if_valid ? 32'h0 : 32'h1);
        end
        chk("starve_grant_count", 32'(g), 32'd10);
        @(posedge clock); #1;
        w_if_req = 1'b0;
        w_dm_req = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        w_mem_ready = 1'b0;
        exp_if = 32'h5555_AAAA;
        exp_dm = 32'h5555_AAAA;
        chk("starve_end_if_rdata", w_if_rdata_32, exp_if);
        chk("starve_end_dm_rdata", w_dm_rdata_32, exp_dm);

        // Flush while in INST, memory answers two cycles later.
        w_if_req     = 1'b1;
        w_if_addr_32 = 32'h0000_0060;
        @(posedge clock); #1;
        w_if_flush = 1'b1;
        @(negedge clock);
        chk("flush_inst_mem_req", 32'(w_mem_req), 32'h1);
        @(posedge clock); #1;
        w_if_flush = 1'b0;
        @(posedge clock); #1;
        w_mem_ready    = 1'b1;
        w_mem_rdata_32 = 32'h7777_0000;
        @(negedge clock);
        chk("flush_inst_mem_req_late", 32'(w_mem_req), 32'h1);
        @(posedge clock); #1;
        w_mem_ready = 1'b0;
        w_if_req    = 1'b0;
        chk("flush_inst_no_valid", 32'(w_if_valid), 32'h0);
        chk("flush_inst_rdata",    w_if_rdata_32,   exp_if);
        chk("flush_inst_done",     32'(w_mem_req),  32'h0);
        @(posedge clock); #1;
        chk("flush_inst_no_valid2", 32'(w_if_valid), 32'h0);
        tail = '{1'b0, 1'b0, 32'h0000_0064, 32'h0, 32'h1111_2222, 1, 32'h1111_2222};
        run_txn(tail, "after_flush");

        // Flush in the grant cycle itself.
        w_if_req     = 1'b1;
        w_if_addr_32 = 32'h0000_0068;
        w_if_flush   = 1'b1;
        @(posedge clock); #1;
        w_if_flush     = 1'b0;
        w_mem_ready    = 1'b1;
        w_mem_rdata_32 = 32'h8888_8888;
        @(posedge clock); #1;
        w_mem_ready = 1'b0;
        w_if_req    = 1'b0;
        chk("flush_grant_no_valid", 32'(w_if_valid), 32'h0);
        chk("flush_grant_rdata",    w_if_rdata_32,   exp_if);
        @(posedge clock); #1;

        // Flush while idle with no fetch grant is ignored.
        w_if_flush = 1'b1;
        @(posedge clock); #1;
        w_if_flush = 1'b0;
        tail = '{1'b0, 1'b0, 32'h0000_006C, 32'h0, 32'h9999_1234, 0, 32'h9999_1234};
        run_txn(tail, "idle_flush");

        // Flush during a data access does not affect it.
        w_if_flush = 1'b1;
        tail = '{1'b1, 1'b0, 32'h0000_0500, 32'h0, 32'h2468_ACE0, 0, 32'h2468_ACE0};
        run_txn(tail, "data_flush");
        w_if_flush = 1'b0;

        // Reset while a load sits in DATA, then the held request reissues.
        w_dm_req     = 1'b1;
        w_dm_write   = 1'b0;
        w_dm_addr_32 = 32'h0000_0400;
        w_mem_ready  = 1'b0;
        @(posedge clock); #1;
        @(negedge clock);
        chk("rst_mid_pre_mem_req", 32'(w_mem_req), 32'h1);
        @(posedge clock); #1;
        reset_n = 1'b0;
        #1;
        chk("rst_mid_mem_req",  32'(w_mem_req),  32'h0);
        chk("rst_mid_mem_addr", w_mem_addr_32,   32'h0);
        chk("rst_mid_dm_rdata", w_dm_rdata_32,   32'h0);
        chk("rst_mid_if_rdata", w_if_rdata_32,   32'h0);
        exp_if = 32'h0;
        exp_dm = 32'h0;
        @(negedge clock);
        chk("rst_mid_no_valid", 32'(w_dm_valid), 32'h0);
        @(posedge clock); #1;
        reset_n        = 1'b1;
        w_mem_ready    = 1'b1;
        w_mem_rdata_32 = 32'hABCD_0123;
        seen = 1'b0;
        for (int c = 0; c < 10 && !seen; c++) begin
            @(posedge clock); #1;
            if (w_dm_valid) seen = 1'b1;
        end
        chk("rst_mid_reissue_valid", 32'(seen), 32'h1);
        chk("rst_mid_reissue_rdata", w_dm_rdata_32, 32'hABCD_0123);
        w_dm_req    = 1'b0;
        w_mem_ready = 1'b0;
        @(posedge clock); #1;
        chk("rst_mid_final_idle", 32'(w_mem_req | w_dm_valid), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
